// File: rtl/keypad_pkg.sv
// Shared keypad definitions: geometry, debouncer state encoding and the
// row/column to hex key-code mapping.
package keypad_pkg;

    localparam int KEY_W = 4;
    localparam int ROWS  = 4;
    localparam int COLS  = 4;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_PEND   = 2'd1,
        HELD         = 2'd2,
        RELEASE_PEND = 2'd3
    } key_state_e;

    function automatic logic [1:0] lowest_set(input logic [3:0] v);
        lowest_set = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (v[i]) lowest_set = 2'(i);
        end
    endfunction

    // code = 4*row_idx + col_idx
    function automatic logic [KEY_W-1:0] key_map(input logic [1:0] row_idx,
                                                 input logic [1:0] col_idx);
        key_map = {row_idx, col_idx};
    endfunction

endpackage

// File: rtl/key_fifo.sv
// Small synchronous FIFO for key codes; head and valid are registered from
// next-state values so they track the pointers with no extra lag.
module key_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_full,
    output logic [WIDTH-1:0] o_head,
    output logic             o_valid
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic [WIDTH-1:0] r_head;
    logic             r_valid;

    logic             w_pop;
    logic             w_push;
    logic [AW-1:0]    w_rd_next;
    logic [AW:0]      w_count_next;
    logic [WIDTH-1:0] w_head_next;

    assign o_full  = (r_count == FULL_CNT);
    assign o_head  = r_head;
    assign o_valid = r_valid;

    // A pop frees the slot in the same cycle, so a full FIFO still accepts a push.
    assign w_pop     = i_pop && (r_count != '0);
    assign w_push    = i_push && (!o_full || w_pop);
    assign w_rd_next = w_pop ? r_rd_ptr + 1'b1 : r_rd_ptr;

    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + 1'b1;
        end else if (!w_push && w_pop) begin
            w_count_next = r_count - 1'b1;
        end
        w_head_next = r_mem[w_rd_next];
        if (w_push && (r_wr_ptr == w_rd_next)) begin
            w_head_next = i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_head   <= '0;
            r_valid  <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            r_rd_ptr <= w_rd_next;
            r_count  <= w_count_next;
            r_head   <= w_head_next;
            r_valid  <= (w_count_next != '0);
        end
    end

endmodule

// File: rtl/keypad_event_debouncer.sv
// Builds one key snapshot per 4-column scan frame, debounces it over whole
// frames and queues one hex code per accepted press.
//
// state        | meaning
// IDLE         | no key down, waiting for a hit frame
// PRESS_PEND   | same key seen for r_cnt consecutive frames
// HELD         | press accepted, code pushed, key_held=1
// RELEASE_PEND | empty frames seen r_cnt times while still held
module keypad_event_debouncer
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_FRAMES = 8,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ROWS-1:0]  i_row,
    input  logic [COLS-1:0]  i_col,
    output logic [KEY_W-1:0] o_key_code,
    output logic             o_key_valid,
    input  logic             i_key_ready,
    output logic             o_key_held,
    output logic             o_overflow
);

    localparam int CNT_W = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_FRAMES - 1);
    localparam logic [COLS-1:0]  LAST_COL = {1'b1, {(COLS-1){1'b0}}};

    logic             r_acc_hit;
    logic [KEY_W-1:0] r_acc_code;
    logic             r_acc_invalid;
    logic             r_snap_valid;
    logic             r_snap_hit;
    logic [KEY_W-1:0] r_snap_code;
    logic             r_snap_invalid;

    key_state_e       r_state;
    key_state_e       w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic [KEY_W-1:0] r_cand;
    logic [KEY_W-1:0] w_cand_next;
    logic             w_push;
    logic             r_overflow;

    logic             w_col_ok;
    logic             w_hit_now;
    logic [KEY_W-1:0] w_code_now;
    logic             w_frame_end;
    logic             w_frame_ok;
    logic             w_full;

    assign w_col_ok    = $onehot(i_col);
    assign w_hit_now   = w_col_ok && (i_row != '0);
    assign w_code_now  = key_map(lowest_set(i_row), lowest_set(i_col));
    assign w_frame_end = (i_col == LAST_COL);

    // First hit of the frame wins; later columns are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc_hit      <= 1'b0;
            r_acc_code     <= '0;
            r_acc_invalid  <= 1'b0;
            r_snap_valid   <= 1'b0;
            r_snap_hit     <= 1'b0;
            r_snap_code    <= '0;
            r_snap_invalid <= 1'b0;
        end else if (w_frame_end) begin
            r_snap_valid   <= 1'b1;
            r_snap_hit     <= r_acc_hit || w_hit_now;
            r_snap_code    <= r_acc_hit ? r_acc_code : w_code_now;
            r_snap_invalid <= r_acc_invalid;
            r_acc_hit      <= 1'b0;
            r_acc_code     <= '0;
            r_acc_invalid  <= 1'b0;
        end else begin
            r_snap_valid <= 1'b0;
            if (!w_col_ok) begin
                r_acc_invalid <= 1'b1;
            end else if (w_hit_now && !r_acc_hit) begin
                r_acc_hit  <= 1'b1;
                r_acc_code <= w_code_now;
            end
        end
    end

    assign w_frame_ok = r_snap_valid && !r_snap_invalid;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_cand_next  = r_cand;
        w_push       = 1'b0;
        if (w_frame_ok) begin
            case (r_state)
                IDLE: begin
                    if (r_snap_hit) begin
                        w_state_next = PRESS_PEND;
                        w_cand_next  = r_snap_code;
                        w_cnt_next   = CNT_W'(1);
                    end
                end
                PRESS_PEND: begin
                    if (!r_snap_hit) begin
                        w_state_next = IDLE;
                        w_cnt_next   = '0;
                    end else if (r_snap_code != r_cand) begin
                        w_cand_next = r_snap_code;
                        w_cnt_next  = CNT_W'(1);
                    end else if (r_cnt == CNT_LAST) begin
                        w_state_next = HELD;
                        w_cnt_next   = '0;
                        w_push       = 1'b1;
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end
                HELD: begin
                    if (!r_snap_hit) begin
                        w_state_next = RELEASE_PEND;
                        w_cnt_next   = CNT_W'(1);
                    end
                end
                RELEASE_PEND: begin
                    if (r_snap_hit) begin
                        w_state_next = HELD;
                        w_cnt_next   = '0;
                    end else if (r_cnt == CNT_LAST) begin
                        w_state_next = IDLE;
                        w_cnt_next   = '0;
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end
                default: begin
                    w_state_next = IDLE;
                    w_cnt_next   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_cand  <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_cand  <= w_cand_next;
        end
    end

    assign o_key_held = (r_state == HELD) || (r_state == RELEASE_PEND);

    key_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (KEY_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (i_key_ready),
        .i_data  (r_cand),
        .o_full  (w_full),
        .o_head  (o_key_code),
        .o_valid (o_key_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (w_push && w_full && !(i_key_ready && o_key_valid)) begin
            r_overflow <= 1'b1;
        end
    end

    assign o_overflow = r_overflow;

endmodule

// File: tb/tb_keypad_event_debouncer.sv
// Directed bench for keypad_event_debouncer: frame-level key stimulus with
// hand-computed expected codes, handshake and overflow behaviour.
module tb_keypad_event_debouncer;

    logic       clk;
    logic       rst;
    logic [3:0] i_row;
    logic [3:0] i_col;
    logic [3:0] o_key_code;
    logic       o_key_valid;
    logic       i_key_ready;
    logic       o_key_held;
    logic       o_overflow;

    int n_vec;
    int n_err;

    keypad_event_debouncer #(
        .DEBOUNCE_FRAMES (8),
        .FIFO_DEPTH      (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_row       (i_row),
        .i_col       (i_col),
        .o_key_code  (o_key_code),
        .o_key_valid (o_key_valid),
        .i_key_ready (i_key_ready),
        .o_key_held  (o_key_held),
        .o_overflow  (o_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] kbit(input int k);
        logic [15:0] one;
        one = 16'h0001;
        return one << k;
    endfunction

    task automatic tick(input logic [3:0] r, input logic [3:0] c);
        i_row = r;
        i_col = c;
        @(posedge clk);
        #1;
    endtask

    // keys bit (4*row + col) set = that key pressed; bad=1 puts col 0011 in slot 1
    task automatic frames(input logic [15:0] keys, input int n, input bit bad);
        for (int f = 0; f < n; f++) begin
            for (int c = 0; c < 4; c++) begin
                logic [3:0] cv;
                cv = 4'b0001 << c;
                if (bad && c == 1) cv = 4'b0011;
                tick({keys[12+c], keys[8+c], keys[4+c], keys[c]}, cv);
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        i_row = 4'b0000;
        i_col = 4'b0000;
        i_key_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        if (o_key_code !== 4'h0) begin $display("FAIL reset_code: got %0h want 0", o_key_code); n_err++; end
        n_vec++;
        if (o_key_valid !== 1'b0) begin $display("FAIL reset_valid: got %0b want 0", o_key_valid); n_err++; end
        n_vec++;
        if (o_key_held !== 1'b0) begin $display("FAIL reset_held: got %0b want 0", o_key_held); n_err++; end
        n_vec++;
        if (o_overflow !== 1'b0) begin $display("FAIL reset_overflow: got %0b want 0", o_overflow); n_err++; end
        n_vec++;
    endtask

    task automatic test_single_press();
        do_reset();
        frames(kbit(5), 8, 1'b0);
        if (o_key_valid !== 1'b0) begin $display("FAIL press_early_valid: got %0b want 0", o_key_valid); n_err++; end
        n_vec++;
        if (o_key_held !== 1'b0) begin $display("FAIL press_early_held: got %0b want 0", o_key_held); n_err++; end
        n_vec++;
        tick(4'b0000, 4'b0001);
        if (o_key_valid !== 1'b1) begin $display("FAIL press_valid: got %0b want 1", o_key_valid); n_err++; end
        n_vec++;
        if (o_key_code !== 4'h5) begin $display("FAIL press_code: got %0h want 5", o_key_code); n_err++; end
        n_vec++;
        if (o_key_held !== 1'b1) begin $display("FAIL press_held: got %0b want 1", o_key_held); n_err++; end
        n_vec++;
        i_key_ready = 1'b1;
        tick(4'b0000, 4'b0001);
        i_key_ready = 1'b0;
        if (o_key_valid !== 1'b0) begin $display("FAIL press_single_push: got valid %0b want 0", o_key_valid); n_err++; end
        n_vec++;
    endtask

    task automatic test_bounce();
        do_reset();
        for (int i = 0; i < 5; i++) frames((i % 2 == 1) ? kbit(8) : 16'h0000, 1, 1'b0);
        frames(kbit(8), 7, 1'b0);
        tick(4'b0000, 4'b0001);
        if (o_key_valid !== 1'b0) begin $display("FAIL bounce_early: got valid %0b want 0", o_key_valid); n_err++; end
        n_vec++;
        frames(kbit(8), 1, 1'b0);
        tick(4'b0000, 4'b0001);
        if (o_key_valid !== 1'b1) begin $display("FAIL bounce_valid: got %0b want 1", o_key_valid); n_err++; end
        n_vec++;
        if (o_key_code !== 4'h8) begin $display("FAIL bounce_code: got %0h want 8", o_key_code); n_err++; end
        n_vec++;
        i_key_ready = 1'b1;
        tick(4'b0000, 4'b0001);
        i_key_ready = 1'b0;
        if (o_key_valid !== 1'b0) begin $display("FAIL bounce_single_push: got valid %0b want 0", o_key_valid); n_err++; end
        n_vec++;
    endtask

    task automatic test_two_keys();
        do_reset();
        frames(kbit(2) | kbit(15), 8, 1'b0);
        tick(4'b0000, 4'b0001);
        if (o_key_code !== 4'h2) begin $display("FAIL two_keys_code: got %0h want 2", o_key_code); n_err++; end
        n_vec++;
        if (o_key_held !== 1'b1) begin $display("FAIL two_keys_held: got %0b want 1", o_key_held); n_err++; end
        n_vec++;
        i_key_ready = 1'b1;
        tick(4'b0000, 4'b0001);
        i_key_ready = 1'b0;
        if (o_key_valid !== 1'b0) begin $display("FAIL two_keys_single_push: got valid %0b want 0", o_key_valid); n_err++; end
        n_vec++;
    endtask

    task automatic test_overflow();
        logic [3:0] codes [5];
        codes = '{4'h1, 4'h6, 4'hB, 4'hC, 4'hF};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            frames(kbit(int'(codes[i])), 8, 1'b0);
            frames(16'h0000, 8, 1'b0);
            if (i == 3) begin
                if (o_overflow !== 1'b0) begin $display("FAIL ovf_at_full: got %0b want 0", o_overflow); n_err++; end
                n_vec++;
            end
        end
        if (o_overflow !== 1'b1) begin $display("FAIL ovf_set: got %0b want 1", o_overflow); n_err++; end
        n_vec++;
        i_key_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (o_key_valid !== 1'b1 || o_key_code !== codes[i]) begin
                $display("FAIL ovf_pop%0d: got valid %0b code %0h want 1 %0h", i, o_key_valid, o_key_code, codes[i]);
                n_err++;
            end
            n_vec++;
            tick(4'b0000, 4'b0001);
        end
        i_key_ready = 1'b0;
        if (o_key_valid !== 1'b0) begin $display("FAIL ovf_drained: got valid %0b want 0", o_key_valid); n_err++; end
        n_vec++;
        if (o_overflow !== 1'b1) begin $display("FAIL ovf_sticky: got %0b want 1", o_overflow); n_err++; end
        n_vec++;
    endtask

    task automatic test_full_push_pop();
        logic [3:0] codes [5];
        codes = '{4'h3, 4'h4, 4'h9, 4'hD, 4'hE};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            frames(kbit(int'(codes[i])), 8, 1'b0);
            frames(16'h0000, 8, 1'b0);
        end
        frames(kbit(int'(codes[4])), 8, 1'b0);
        i_key_ready = 1'b1;
        tick(4'b0000, 4'b0001);
        i_key_ready = 1'b0;
        if (o_overflow !== 1'b0) begin $display("FAIL pushpop_no_ovf: got %0b want 0", o_overflow); n_err++; end
        n_vec++;
        i_key_ready = 1'b1;
        for (int i = 1; i < 5; i++) begin
            if (o_key_valid !== 1'b1 || o_key_code !== codes[i]) begin
                $display("FAIL pushpop_pop%0d: got valid %0b code %0h want 1 %0h", i, o_key_valid, o_key_code, codes[i]);
                n_err++;
            end
            n_vec++;
            tick(4'b0000, 4'b0001);
        end
        i_key_ready = 1'b0;
        if (o_key_valid !== 1'b0) begin $display("FAIL pushpop_drained: got valid %0b want 0", o_key_valid); n_err++; end
        n_vec++;
    endtask

    task automatic test_release_glitch();
        do_reset();
        frames(kbit(5), 20, 1'b0);
        frames(16'h0000, 3, 1'b0);
        tick(4'b0000, 4'b0001);
        if (o_key_held !== 1'b1) begin $display("FAIL glitch_held_mid: got %0b want 1", o_key_held); n_err++; end
        n_vec++;
        frames(kbit(5), 8, 1'b0);
        tick(4'b0000, 4'b0001);
        if (o_key_held !== 1'b1) begin $display("FAIL glitch_held: got %0b want 1", o_key_held); n_err++; end
        n_vec++;
        if (o_key_valid !== 1'b1 || o_key_code !== 4'h5) begin
            $display("FAIL glitch_code: got valid %0b code %0h want 1 5", o_key_valid, o_key_code);
            n_err++;
        end
        n_vec++;
        i_key_ready = 1'b1;
        tick(4'b0000, 4'b0001);
        i_key_ready = 1'b0;
        if (o_key_valid !== 1'b0) begin $display("FAIL glitch_no_repeat: got valid %0b want 0", o_key_valid); n_err++; end
        n_vec++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        frames(kbit(10), 8, 1'b0);
        frames(16'h0000, 8, 1'b0);
        frames(kbit(3), 8, 1'b0);
        frames(16'h0000, 8, 1'b0);
        frames(kbit(7), 6, 1'b0);
        frames(kbit(7), 2, 1'b1);
        frames(kbit(7), 1, 1'b0);
        tick(4'b0000, 4'b0001);
        if (o_key_held !== 1'b0) begin $display("FAIL invalid_frames_held: got %0b want 0", o_key_held); n_err++; end
        n_vec++;
        if (o_key_valid !== 1'b1 || o_key_code !== 4'hA) begin
            $display("FAIL rstmid_head: got valid %0b code %0h want 1 a", o_key_valid, o_key_code);
            n_err++;
        end
        n_vec++;
        #1 rst = 1'b1;
        #1;
        if (o_key_valid !== 1'b0) begin $display("FAIL rstmid_valid: got %0b want 0", o_key_valid); n_err++; end
        n_vec++;
        if (o_key_code !== 4'h0) begin $display("FAIL rstmid_code: got %0h want 0", o_key_code); n_err++; end
        n_vec++;
        if (o_key_held !== 1'b0) begin $display("FAIL rstmid_held: got %0b want 0", o_key_held); n_err++; end
        n_vec++;
        @(posedge clk);
        #1 rst = 1'b0;
        frames(kbit(7), 1, 1'b0);
        tick(4'b0000, 4'b0001);
        if (o_key_valid !== 1'b0) begin $display("FAIL rstmid_no_push: got valid %0b want 0", o_key_valid); n_err++; end
        n_vec++;
        frames(kbit(7), 6, 1'b0);
        frames(kbit(7), 2, 1'b1);
        tick(4'b0000, 4'b0001);
        if (o_key_valid !== 1'b0 || o_key_held !== 1'b0) begin
            $display("FAIL rstmid_hold_cnt: got valid %0b held %0b want 0 0", o_key_valid, o_key_held);
            n_err++;
        end
        n_vec++;
        frames(kbit(7), 1, 1'b0);
        tick(4'b0000, 4'b0001);
        if (o_key_valid !== 1'b1 || o_key_code !== 4'h7) begin
            $display("FAIL rstmid_repress: got valid %0b code %0h want 1 7", o_key_valid, o_key_code);
            n_err++;
        end
        n_vec++;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        i_row = 4'b0000;
        i_col = 4'b0000;
        i_key_ready = 1'b0;
        test_reset();
        test_single_press();
        test_bounce();
        test_two_keys();
        test_overflow();
        test_full_push_pop();
        test_release_glitch();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
